// File: rtl/raster.sv
`default_nettype none
// ============================================================================
// Module   : raster
// Brief    : Flat-shaded triangle scan converter. Walks the screen-clipped
//            bounding box row-major and streams covered pixels over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module raster #(
    parameter int COORD_WIDTH = 16,
    parameter int COLOR_WIDTH = 16,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [COORD_WIDTH-1:0] vertexes [3][3],
    input  logic [COLOR_WIDTH-1:0] colors,
    output logic                   busy,
    output logic                   done,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic [COORD_WIDTH-1:0] pix_x,
    output logic [COORD_WIDTH-1:0] pix_y,
    output logic [COLOR_WIDTH-1:0] pix_color
);
    localparam int EW = 2 * COORD_WIDTH + 4;
    localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(SCREEN_W - 1);
    localparam logic [COORD_WIDTH-1:0] Y_LAST = COORD_WIDTH'(SCREEN_H - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SCAN  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state, state_next;

    logic [COORD_WIDTH-1:0] vx [3];
    logic [COORD_WIDTH-1:0] vy [3];
    logic [COLOR_WIDTH-1:0] color_q;
    logic [COORD_WIDTH-1:0] xmin, xmax, ymax, cx, cy;
    logic                   area_pos;

    logic [COORD_WIDTH-1:0] bx_min, bx_max, by_min, by_max;
    logic signed [EW-1:0]   area, e01, e12, e20;
    logic                   empty, covered, advance, last_cand;
    logic                   unused_z;

    // Zero-extended operands in a wide signed word cannot overflow the
    // difference-of-products.
    function automatic logic signed [EW-1:0] edge_fn(
        input logic [COORD_WIDTH-1:0] xi, input logic [COORD_WIDTH-1:0] yi,
        input logic [COORD_WIDTH-1:0] xj, input logic [COORD_WIDTH-1:0] yj,
        input logic [COORD_WIDTH-1:0] px, input logic [COORD_WIDTH-1:0] py);
        logic signed [EW-1:0] a, b, c, d;
        a = EW'(xj) - EW'(xi);
        b = EW'(py) - EW'(yi);
        c = EW'(yj) - EW'(yi);
        d = EW'(px) - EW'(xi);
        return a * b - c * d;
    endfunction

    assign unused_z = ^{vertexes[0][2], vertexes[1][2], vertexes[2][2]};

    always_comb begin
        bx_min = vx[0];
        bx_max = vx[0];
        by_min = vy[0];
        by_max = vy[0];
        for (int i = 1; i < 3; i++) begin
            if (vx[i] < bx_min) bx_min = vx[i];
            if (vx[i] > bx_max) bx_max = vx[i];
            if (vy[i] < by_min) by_min = vy[i];
            if (vy[i] > by_max) by_max = vy[i];
        end
        if (bx_max > X_LAST) bx_max = X_LAST;
        if (by_max > Y_LAST) by_max = Y_LAST;
    end

    assign area  = edge_fn(vx[0], vy[0], vx[1], vy[1], vx[2], vy[2]);
    assign empty = (area == '0) || (bx_min > X_LAST) || (by_min > Y_LAST);

    assign e01 = edge_fn(vx[0], vy[0], vx[1], vy[1], cx, cy);
    assign e12 = edge_fn(vx[1], vy[1], vx[2], vy[2], cx, cy);
    assign e20 = edge_fn(vx[2], vy[2], vx[0], vy[0], cx, cy);

    // Sign bit clear means >= 0; a set sign bit or zero means <= 0.
    assign covered = area_pos
        ? (!e01[EW-1] && !e12[EW-1] && !e20[EW-1])
        : ((e01[EW-1] || e01 == '0) && (e12[EW-1] || e12 == '0) &&
           (e20[EW-1] || e20 == '0));

    assign advance   = !pix_valid || pix_ready;
    assign last_cand = (cx == xmax) && (cy == ymax);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = (state == DONE);
        case (state)
            IDLE:    if (start) state_next = SETUP;
            SETUP:   state_next = empty ? DONE : SCAN;
            SCAN:    if (advance && last_cand) state_next = DRAIN;
            DRAIN:   if (advance) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                vx[i] <= '0;
                vy[i] <= '0;
            end
            color_q   <= '0;
            xmin      <= '0;
            xmax      <= '0;
            ymax      <= '0;
            cx        <= '0;
            cy        <= '0;
            area_pos  <= 1'b0;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_color <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    for (int i = 0; i < 3; i++) begin
                        vx[i] <= vertexes[i][0];
                        vy[i] <= vertexes[i][1];
                    end
                    color_q <= colors;
                end
                SETUP: begin
                    xmin     <= bx_min;
                    xmax     <= bx_max;
                    ymax     <= by_max;
                    cx       <= bx_min;
                    cy       <= by_min;
                    area_pos <= !area[EW-1];
                end
                SCAN: if (advance) begin
                    if (covered) begin
                        pix_valid <= 1'b1;
                        pix_x     <= cx;
                        pix_y     <= cy;
                        pix_color <= color_q;
                    end else if (pix_ready) begin
                        pix_valid <= 1'b0;
                    end
                    if (cx == xmax) begin
                        cx <= xmin;
                        cy <= cy + 1'b1;
                    end else begin
                        cx <= cx + 1'b1;
                    end
                end
                DRAIN: if (pix_ready) pix_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_raster.sv
`default_nettype none
// ============================================================================
// Module   : tb_raster
// Brief    : Directed and randomized bench for raster with a box-walking
//            reference model of triangle coverage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_raster;
    localparam int CW = 16;
    localparam int KW = 16;
    localparam int SW = 640;
    localparam int SH = 480;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [KW-1:0] c;
    } frag_t;

    logic          clk = 1'b0;
    logic          reset, start, pix_ready;
    logic          busy, done, pix_valid;
    logic [CW-1:0] vertexes [3][3];
    logic [KW-1:0] colors;
    logic [CW-1:0] pix_x, pix_y;
    logic [KW-1:0] pix_color;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    rmode = 0;
    frag_t got[$];
    frag_t exp_q[$];
    int    done_cnt = 0, busy_cnt = 0, valid_cnt = 0, done_cyc = 0, last_hs = 0;
    int    b_done, b_busy, b_valid, b_got, t0;
    int    vx[3], vy[3];
    bit    m_empty;
    int    m_cells;
    bit    prev_stall = 1'b0;
    frag_t held;

    raster #(.COORD_WIDTH(CW), .COLOR_WIDTH(KW), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .clk(clk), .reset(reset), .start(start), .vertexes(vertexes),
        .colors(colors), .busy(busy), .done(done), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = 1'($urandom_range(0, 1));
                default: pix_ready = 1'b0;
            endcase
        end
    end

    // Observes the stream: logs handshakes, counts pulses, and enforces hold-under-stall.
    always @(negedge clk) begin
        if (!reset) begin
            if (busy) busy_cnt++;
            if (pix_valid) valid_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (prev_stall) begin
                checks++;
                assert ({pix_valid, pix_x, pix_y, pix_color} === {1'b1, held})
                else begin
                    errors++;
                    $error("FAIL stall_hold observed=%0h expected=%0h",
                           {pix_valid, pix_x, pix_y, pix_color}, {1'b1, held});
                end
            end
            if (pix_valid && pix_ready) begin
                got.push_back({pix_x, pix_y, pix_color});
                last_hs = cyc;
            end
            prev_stall = pix_valid && !pix_ready;
            held       = {pix_x, pix_y, pix_color};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint efn(int i, int j, longint px, longint py);
        return (longint'(vx[j]) - vx[i]) * (py - vy[i]) -
               (longint'(vy[j]) - vy[i]) * (px - vx[i]);
    endfunction

    // Enumerates the clipped box row-major and keeps every pixel on the inner side of all edges.
    task automatic model(input logic [KW-1:0] col);
        int xmn, xmx, ymn, ymx;
        longint a, e0, e1, e2;
        exp_q.delete();
        xmn = vx[0]; xmx = vx[0]; ymn = vy[0]; ymx = vy[0];
        for (int i = 1; i < 3; i++) begin
            if (vx[i] < xmn) xmn = vx[i];
            if (vx[i] > xmx) xmx = vx[i];
            if (vy[i] < ymn) ymn = vy[i];
            if (vy[i] > ymx) ymx = vy[i];
        end
        if (xmx > SW - 1) xmx = SW - 1;
        if (ymx > SH - 1) ymx = SH - 1;
        a = efn(0, 1, vx[2], vy[2]);
        m_empty = (a == 0) || (xmn > SW - 1) || (ymn > SH - 1);
        m_cells = (xmx - xmn + 1) * (ymx - ymn + 1);
        if (!m_empty) begin
            for (int y = ymn; y <= ymx; y++) begin
                for (int x = xmn; x <= xmx; x++) begin
                    e0 = efn(0, 1, x, y);
                    e1 = efn(1, 2, x, y);
                    e2 = efn(2, 0, x, y);
                    if ((a > 0 && e0 >= 0 && e1 >= 0 && e2 >= 0) ||
                        (a < 0 && e0 <= 0 && e1 <= 0 && e2 <= 0))
                        exp_q.push_back({CW'(x), CW'(y), col});
                end
            end
        end
    endtask

    task automatic set_tri(input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2);
        vx[0] = x0; vy[0] = y0; vx[1] = x1; vy[1] = y1; vx[2] = x2; vy[2] = y2;
    endtask

    task automatic launch(input logic [KW-1:0] col, input int rm);
        rmode = rm;
        model(col);
        b_done = done_cnt; b_busy = busy_cnt; b_valid = valid_cnt; b_got = got.size();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            vertexes[i][0] = CW'(vx[i]);
            vertexes[i][1] = CW'(vy[i]);
            vertexes[i][2] = CW'($urandom);
        end
        colors = col;
        start  = 1'b1;
        t0     = cyc;
        @(posedge clk);
        #1;
        start  = 1'b0;
        colors = KW'($urandom);
        for (int i = 0; i < 3; i++) begin
            vertexes[i][0] = CW'($urandom);
            vertexes[i][1] = CW'($urandom);
        end
    endtask

    task automatic finish_wait(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_run(input string tag, input bit ok, input bit exact);
        chk({tag, "_completed"}, 64'(ok), 64'd1);
        chk({tag, "_done_pulses"}, 64'(done_cnt - b_done), 64'd1);
        chk({tag, "_frag_count"}, 64'(got.size() - b_got), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && b_got + i < got.size(); i++)
            chk($sformatf("%s_frag%0d", tag, i), 64'(got[b_got + i]), 64'(exp_q[i]));
        chk({tag, "_busy_span"}, 64'(busy_cnt - b_busy), 64'(done_cyc - t0));
        if (m_empty) chk({tag, "_no_valid"}, 64'(valid_cnt - b_valid), 64'd0);
        if (m_empty || exact)
            chk({tag, "_done_time"}, 64'(done_cyc - t0), 64'(m_empty ? 2 : 3 + m_cells));
        else if (exp_q.size() > 0)
            chk({tag, "_done_after_hs"}, 64'(done_cyc > last_hs), 64'd1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_valid"}, 64'(pix_valid), 64'd0);
        chk({tag, "_x"}, 64'(pix_x), 64'd0);
        chk({tag, "_y"}, 64'(pix_y), 64'd0);
        chk({tag, "_color"}, 64'(pix_color), 64'd0);
    endtask

    initial begin
        bit ok;
        int rm;
        reset = 1'b1;
        start = 1'b0;
        colors = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) vertexes[i][j] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        set_tri(0, 0, 3, 0, 0, 3);
        launch(16'h1234, 0);
        finish_wait(ok);
        check_run("basic", ok, 1'b1);

        set_tri(0, 0, 0, 3, 3, 0);
        launch(16'h1234, 0);
        finish_wait(ok);
        check_run("winding", ok, 1'b1);

        set_tri(0, 0, 2, 2, 4, 4);
        launch(16'hBEEF, 0);
        finish_wait(ok);
        check_run("collinear", ok, 1'b1);

        set_tri(700, 10, 650, 20, 660, 30);
        launch(16'hBEEF, 0);
        finish_wait(ok);
        check_run("offscreen", ok, 1'b1);

        set_tri(0, 0, 3, 0, 0, 3);
        launch(16'h1234, 2);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (pix_valid) break;
        end
        chk("bp_first_valid", 64'(pix_valid), 64'd1);
        chk("bp_first_xy", 64'({pix_x, pix_y}), 64'd0);
        repeat (5) @(negedge clk);
        chk("bp_held_valid", 64'(pix_valid), 64'd1);
        chk("bp_no_accept", 64'(got.size() - b_got), 64'd0);
        rmode = 1;
        finish_wait(ok);
        check_run("backpressure", ok, 1'b0);

        set_tri(630, 0, 700, 0, 630, 5);
        launch(16'h00FF, 0);
        finish_wait(ok);
        check_run("clip", ok, 1'b1);

        for (int k = 0; k < 6; k++) begin
            rm = int'($urandom_range(0, 1));
            set_tri($urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 20),
                    $urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 20));
            launch(KW'($urandom), rm);
            finish_wait(ok);
            check_run($sformatf("rand%0d", k), ok, rm == 0);
        end

        for (int k = 0; k < 2; k++) begin
            set_tri($urandom_range(615, 660), $urandom_range(460, 495), $urandom_range(615, 660),
                    $urandom_range(460, 495), $urandom_range(615, 660), $urandom_range(460, 495));
            launch(KW'($urandom), 0);
            finish_wait(ok);
            check_run($sformatf("edge%0d", k), ok, 1'b1);
        end

        set_tri(0, 0, 3, 0, 0, 3);
        launch(16'h1234, 0);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (got.size() - b_got >= 4) break;
        end
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_idle("abort");
        repeat (20) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - b_done), 64'd0);

        set_tri(0, 0, 3, 0, 0, 3);
        launch(16'h1234, 0);
        finish_wait(ok);
        check_run("rerun", ok, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/raster.md
# raster

Triangle scan-converter directly downstream of the vertex/colour fetch stage. On `start` it latches three screen-space vertices and a flat colour, computes a screen-clipped bounding box and the signed triangle area, then walks the box row-major. It emits one `(x, y, colour)` fragment per covered pixel over a valid/ready stream toward the pixel writer, and pulses `done` when the triangle is finished.

## Interface
- `COORD_WIDTH`, 16: width of each vertex component; x/y are treated as unsigned pixel coordinates.
- `COLOR_WIDTH`, 16: width of the flat colour.
- `SCREEN_W`, 640: horizontal resolution; legal x is 0..SCREEN_W-1.
- `SCREEN_H`, 480: vertical resolution; legal y is 0..SCREEN_H-1.
- `clk`  in  1  single clock; everything is on the rising edge.
- `reset`  in  1  **synchronous, active-high** reset.
- `start`  in  1  begin a triangle; sampled only in IDLE.
- `vertexes`  in  [COORD_WIDTH-1:0] [3][3]  `vertexes[i][0]` = x, `[i][1]` = y, `[i][2]` = z (z is ignored); sampled in the `start` cycle.
- `colors`  in  COLOR_WIDTH  flat triangle colour; sampled in the `start` cycle.
- `busy`  out  1  high whenever state != IDLE.
- `done`  out  1  one-cycle pulse at triangle completion.
- `pix_valid`  out  1  a fragment is presented.
- `pix_ready`  in  1  the consumer accepts the fragment.
- `pix_x`, `pix_y`  out  COORD_WIDTH  fragment coordinates.
- `pix_color`  out  COLOR_WIDTH  fragment colour (the latched `colors`).

## Operation
- **States:** IDLE, SETUP, SCAN, DRAIN, DONE.
- **IDLE → SETUP** on `start`.
  - Latches x/y of all three vertices and the colour.
  - `start` in any other state is ignored.
- **SETUP** (one cycle):
  - Bounding box: xmin = min(x0, x1, x2), xmax = min(max(x0, x1, x2), SCREEN_W-1); ymin and ymax likewise with SCREEN_H-1.
  - Area A = E01(v2), using the edge function defined below.
  - Empty if A == 0, or xmin > SCREEN_W-1, or ymin > SCREEN_H-1. Empty → DONE; otherwise → SCAN with candidate (cx, cy) = (xmin, ymin).
- **Edge function:** Eij(p) = (xj-xi)*(py-yi) - (yj-yi)*(px-xi).
  - Operands are zero-extended to COORD_WIDTH+1 signed bits.
  - Products and sums are held in 2*COORD_WIDTH+4 signed bits, so no overflow is possible.
- **Coverage test:** the candidate p is inside iff E01(p), E12(p) and E20(p) are all ≥ 0 when A > 0, or all ≤ 0 when A < 0.
  - Edges are inclusive; there is no top-left rule.
  - Either winding produces the same pixel set.
- **SCAN:** evaluates one candidate per advance.
  - The candidate advances when `!pix_valid || pix_ready`.
  - Covered candidate: it is loaded into the output register (`pix_valid`=1, with x, y and colour).
  - Uncovered candidate: `pix_valid` is cleared if the held fragment was accepted; nothing new is loaded.
  - Order: cx increments to xmax, then cx = xmin and cy++.
  - After candidate (xmax, ymax) → DRAIN.
- **DRAIN:** wait until `pix_valid` is 0, or `pix_valid && pix_ready` is seen. Then → DONE.
- **DONE:** `done` = 1 for exactly one cycle, then → IDLE.
- Fragments are emitted in strict row-major order with no duplicates and no drops.

## Timing
- **Reset values:** state IDLE; `busy` 0; `done` 0; `pix_valid` 0; `pix_x`, `pix_y`, `pix_color` 0.
- **Reset mid-triangle:** aborts immediately. No `done`; any pending fragment is discarded.
- **Start sequence** (`start` in cycle T):
  - SETUP occupies T+1.
  - The first candidate is evaluated in T+2.
  - If that candidate is covered, `pix_valid` rises in T+3.
- **Empty triangle:** `done` is high in T+2, `busy` is high in T+1..T+2, and no fragment is emitted.
- **Throughput:** one candidate per cycle with `pix_ready` held high. A box of W×H cycles spends W*H cycles in SCAN.
- **Output stability:** while `pix_valid && !pix_ready`, `pix_x`, `pix_y` and `pix_color` are held stable and the scan stalls.
- **Completion:** `done` is asserted in the cycle after the final fragment handshake, or after the last candidate if no fragment is pending.
- **Back-to-back triangles:** `start` may be asserted in the cycle after `done`. `start` coincident with `done` is ignored.
- **Simultaneous events:** on a covered candidate with `pix_valid && pix_ready`, the register is reloaded in the same cycle and `pix_valid` stays 1.

## Test plan
- **Basic coverage.** Stimulus: v=(0,0),(3,0),(0,3), colour 0x1234, `pix_ready`=1. Required: exactly 10 fragments in order (0,0)(1,0)(2,0)(3,0)(0,1)(1,1)(2,1)(0,2)(1,2)(0,3), all colour 0x1234; `done` pulses once; 16 SCAN cycles.
- **Winding independence.** Stimulus: v=(0,0),(0,3),(3,0). Required: the same 10 fragments in the same order.
- **Degenerate triangle.** Stimulus: collinear v=(0,0),(2,2),(4,4), `start` at T. Required: no `pix_valid`; `done` at T+2. Same result for v=(700,10),(650,20),(660,30) with SCREEN_W=640.
- **Backpressure.** Stimulus: basic triangle with `pix_ready` low for 5 cycles while (0,0) is presented, then random ready. Required: (0,0) held stable throughout, the full 10-fragment sequence is unchanged, and `done` follows the final handshake.
- **Clipping.** Stimulus: v=(630,0),(700,0),(630,5). Required: no fragment with x>639; the row-0 fragments are x=630..639.
- **Reset mid-scan.** Stimulus: `reset` asserted after the 4th fragment, followed by `start` with the basic triangle. Required: outputs return to reset values, no `done` for the aborted triangle, and the second run emits all 10 fragments.
